// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for a shared ALU.
// Filters unsupported opcodes, issues one op at a time, returns results.
module alu_req_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_mode,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_mode,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,

  output logic              alu_en,
  output logic              alu_a_en,
  output logic              alu_b_en,
  output logic [2:0]        alu_a_op,
  output logic [1:0]        alu_b_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_last;
  logic              r_gid;
  logic [1:0]        r_mode;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_data;
  logic              r_err;

  logic              w_any;
  logic              w_gnt;
  logic              w_hs;
  logic              w_legal;
  logic              w_rsp_hs;
  logic              w_issue;
  logic              w_resp;
  logic [1:0]        w_mode;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    w_any = req0_valid | req1_valid;
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = ~r_last;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end
    w_mode = w_gnt ? req1_mode : req0_mode;
    w_op   = w_gnt ? req1_op   : req0_op;
    w_a    = w_gnt ? req1_a    : req0_a;
    w_b    = w_gnt ? req1_b    : req0_b;
  end

  always_comb begin
    w_hs       = (r_state == S_IDLE) && w_any;
    req0_ready = w_hs && !w_gnt;
    req1_ready = w_hs &&  w_gnt;
  end

  always_comb begin
    w_legal = 1'b0;
    case (w_mode)
      2'b01:   w_legal = (w_op != 3'd7);
      2'b10:   w_legal = (w_op <= 3'd2);
      2'b11:   w_legal = !w_op[2];
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_rsp_hs = (r_state == S_RESP)
             && (r_gid ? rsp1_ready : rsp0_ready);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next = w_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP: begin
        if (w_rsp_hs) begin
          w_next = S_IDLE;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_gid  <= 1'b0;
      r_mode <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_gid  <= w_gnt;
        r_last <= w_gnt;
        r_mode <= w_mode;
        r_op   <= w_op;
        r_a    <= w_a;
        r_b    <= w_b;
        r_data <= '0;
        r_err  <= !w_legal;
      end
      if (r_state == S_CAPTURE) begin
        r_data <= alu_c;
        r_err  <= 1'b0;
      end
    end
  end

  // ALU lines are quiet except for the single issue cycle.
  always_comb begin
    w_issue  = (r_state == S_ISSUE);
    alu_en   = w_issue;
    alu_a_en = w_issue && r_mode[0];
    alu_b_en = w_issue && r_mode[1];
    alu_a_op = alu_a_en ? r_op : '0;
    alu_b_op = alu_b_en ? r_op[1:0] : '0;
    alu_a    = w_issue ? r_a : '0;
    alu_b    = w_issue ? r_b : '0;
  end

  always_comb begin
    w_resp     = (r_state == S_RESP);
    rsp0_valid = w_resp && !r_gid;
    rsp1_valid = w_resp &&  r_gid;
    rsp0_data  = rsp0_valid ? r_data : '0;
    rsp1_data  = rsp1_valid ? r_data : '0;
    rsp0_err   = rsp0_valid && r_err;
    rsp1_err   = rsp1_valid && r_err;
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural ALU plus
// a transaction-timeline reference model.
module tb_alu_req_arbiter;

  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   mode;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_mode, req1_mode;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_err, rsp1_err;
  logic         alu_en, alu_a_en, alu_b_en;
  logic [2:0]   alu_a_op;
  logic [1:0]   alu_b_op;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_c = '0;

  alu_req_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_mode(req0_mode), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_mode(req1_mode), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_en(alu_en), .alu_a_en(alu_a_en), .alu_b_en(alu_b_en),
    .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] a_fn(
    input logic [2:0] op, input logic [W-1:0] a, b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a - 8'd1;
      3'd3:    return a + 8'd1;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [W-1:0] b_fn(
    input logic [1:0] op, input logic [W-1:0] a, b);
    case (op)
      2'd0:    return {a[6:0], 1'b0};
      2'd1:    return {1'b0, a[7:1]};
      2'd2:    return {a[6:0], a[7]};
      default: return b;
    endcase
  endfunction

  // Registered ALU stand-in: result appears the cycle after alu_en.
  always @(posedge clk) begin
    if (alu_en) begin
      if (alu_a_en)      alu_c <= a_fn(alu_a_op, alu_a, alu_b);
      else if (alu_b_en) alu_c <= b_fn(alu_b_op, alu_a, alu_b);
      else               alu_c <= '0;
    end
  end

  function automatic bit ref_legal(input logic [1:0] mode,
                                   input logic [2:0] op);
    int o;
    o = int'(op);
    case (mode)
      2'b01:   return o <= 6;
      2'b10:   return o <= 2;
      2'b11:   return o <= 3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_result(input req_t r);
    if (!ref_legal(r.mode, r.op)) return '0;
    if (r.mode[0]) return a_fn(r.op, r.a, r.b);
    return b_fn(r.op[1:0], r.a, r.b);
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  req_t q0[$];
  req_t q1[$];
  int   gap0 = 0, gap1 = 0;
  int   low0 = 0, low1 = 0;
  int   rst_cnt = 0;
  int   quiet = 0;
  bit   arm_rst = 0;
  bit   rand_rdy = 0;

  // Model: one transaction in flight, timed from its accept cycle.
  bit       m_busy = 0;
  bit       m_last = 1;
  bit       m_gid = 0;
  bit       m_legal = 0;
  int       m_cnt = 0;
  req_t     m_req;
  logic [W-1:0] m_res;

  task automatic push(input int n, input logic [1:0] mode,
                      input logic [2:0] op,
                      input logic [W-1:0] a, b);
    req_t r;
    r.mode = mode; r.op = op; r.a = a; r.b = b;
    if (n == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic step();
    bit   do_rst, v0, v1, e_r0, e_r1, e_g;
    bit   e_issue, e_resp, e_v0, e_v1;
    req_t h0, h1;
    logic [23:0] e_alu;
    @(negedge clk);
    if (arm_rst && m_busy && m_legal && m_cnt == 2) begin
      rst_cnt = 1;
      arm_rst = 0;
    end
    do_rst = (rst_cnt > 0);
    rst_n  = !do_rst;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    v0 = !do_rst && quiet == 0 && q0.size() > 0 && gap0 == 0;
    v1 = !do_rst && quiet == 0 && q1.size() > 0 && gap1 == 0;
    req0_valid = v0;
    req0_mode = h0.mode; req0_op = h0.op;
    req0_a = h0.a; req0_b = h0.b;
    req1_valid = v1;
    req1_mode = h1.mode; req1_op = h1.op;
    req1_a = h1.a; req1_b = h1.b;
    rsp0_ready = (low0 > 0) ? 1'b0 :
                 (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    rsp1_ready = (low1 > 0) ? 1'b0 :
                 (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    #1;
    e_r0 = 0; e_r1 = 0; e_g = 0;
    if (!m_busy) begin
      e_g  = (v0 && v1) ? !m_last : v1;
      e_r0 = v0 && !e_g;
      e_r1 = v1 && e_g;
    end
    e_issue = m_busy && m_legal && m_cnt == 1;
    e_resp  = m_busy && (m_legal ? m_cnt >= 3 : m_cnt >= 1);
    e_v0 = e_resp && !m_gid;
    e_v1 = e_resp && m_gid;
    e_alu = '0;
    if (e_issue) begin
      e_alu = {1'b1, m_req.mode[0], m_req.mode[1],
               m_req.mode[0] ? m_req.op : 3'd0,
               m_req.mode[1] ? m_req.op[1:0] : 2'd0,
               m_req.a, m_req.b};
    end
    check("ready", {30'd0, req0_ready, req1_ready},
          {30'd0, e_r0, e_r1});
    check("rsp0", {22'd0, rsp0_valid, rsp0_err, rsp0_data},
          {22'd0, e_v0, e_v0 && !m_legal, e_v0 ? m_res : 8'd0});
    check("rsp1", {22'd0, rsp1_valid, rsp1_err, rsp1_data},
          {22'd0, e_v1, e_v1 && !m_legal, e_v1 ? m_res : 8'd0});
    check("alu", {8'd0, alu_en, alu_a_en, alu_b_en, alu_a_op,
                  alu_b_op, alu_a, alu_b}, {8'd0, e_alu});
    if (low0 > 0 && e_v0) low0--;
    if (low1 > 0 && e_v1) low1--;
    if (do_rst) begin
      m_busy = 0; m_last = 1; quiet = 1; rst_cnt--;
    end else begin
      if (quiet > 0) quiet--;
      if (gap0 > 0) gap0--;
      if (gap1 > 0) gap1--;
      if (e_r0 || e_r1) begin
        m_req = e_g ? q1.pop_front() : q0.pop_front();
        m_gid = e_g; m_last = e_g;
        m_legal = ref_legal(m_req.mode, m_req.op);
        m_res = ref_result(m_req);
        m_busy = 1; m_cnt = 1;
        if (e_g) gap1 = rand_rdy ? $urandom_range(0, 2) : 0;
        else     gap0 = rand_rdy ? $urandom_range(0, 2) : 0;
      end else if (e_resp &&
                   (m_gid ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_cnt++;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_mode = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_mode = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (3) @(posedge clk);

    step(); step();

    push(0, 2'b01, 3'd0, 8'h05, 8'h03);
    drain();
    push(1, 2'b11, 3'd2, 8'h00, 8'h07);
    drain();

    rst_cnt = 1;
    step();
    push(0, 2'b01, 3'd4, 8'hF0, 8'h3C);
    push(0, 2'b10, 3'd1, 8'h82, 8'h00);
    push(1, 2'b01, 3'd1, 8'h10, 8'h20);
    push(1, 2'b11, 3'd3, 8'h7F, 8'h01);
    drain();

    push(0, 2'b01, 3'd7, 8'h12, 8'h34);
    push(0, 2'b10, 3'd3, 8'h56, 8'h78);
    push(0, 2'b00, 3'd0, 8'h9A, 8'hBC);
    drain();

    low0 = 5;
    push(0, 2'b01, 3'd1, 8'h20, 8'h05);
    step(); step();
    push(1, 2'b10, 3'd1, 8'h81, 8'h00);
    drain();

    arm_rst = 1;
    push(0, 2'b01, 3'd3, 8'h10, 8'h00);
    drain();
    push(0, 2'b01, 3'd6, 8'hAA, 8'h0F);
    push(1, 2'b01, 3'd5, 8'h0A, 8'h50);
    drain();

    rand_rdy = 1;
    for (int i = 0; i < 800; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0)
        push(0, 2'($urandom), 3'($urandom),
             8'($urandom), 8'($urandom));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        push(1, 2'($urandom), 3'($urandom),
             8'($urandom), 8'($urandom));
      step();
    end
    rand_rdy = 0;
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
